// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage: FSM encoding,
// reset/bubble constants and the IF/ID register payload.
package fetch_unit_pkg;

  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load.
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid
);

  ifid_t q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: 32'd0, pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else if (!hold && load) begin
      q <= '{pc: pc, pc4: pc + 32'd4, instr: instr, valid: 1'b1};
    end
  end

  assign ifid_pc    = q.pc;
  assign ifid_pc4   = q.pc4;
  assign ifid_instr = q.instr;
  assign ifid_valid = q.valid;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, FETCH/HOLD/DRAIN sequencing against a
// busy-waiting instruction memory, redirect handling and IF/ID decode fields.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDRESS,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_INSTRUCTION,
  output logic        IFID_VALID,
  output logic [7:0]  OPCODE,
  output logic [2:0]  FUNC3,
  output logic [6:0]  FUNC7,
  output logic        FETCH_BUSY
);

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drain_addr, drain_addr_nxt;
  logic [31:0] buf_pc, buf_pc_nxt;
  logic [31:0] buf_instr, buf_instr_nxt;

  logic        ifid_load, ifid_flush, ifid_hold;
  logic [31:0] ifid_src_pc, ifid_src_instr;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    buf_pc_nxt     = buf_pc;
    buf_instr_nxt  = buf_instr;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_hold      = 1'b0;
    ifid_src_pc    = pc;
    ifid_src_instr = IMEM_READDATA;

    if (BRANCH_TAKEN) begin
      // Redirect wins over stall and over any word completing this cycle.
      pc_nxt        = word_align(BRANCH_TARGET);
      ifid_flush    = 1'b1;
      buf_pc_nxt    = 32'd0;
      buf_instr_nxt = NOP_INSTR;
      case (state)
        ST_FETCH: begin
          if (IMEM_BUSYWAIT) begin
            state_nxt      = ST_DRAIN;
            drain_addr_nxt = pc;
          end
        end
        ST_DRAIN: state_nxt = IMEM_BUSYWAIT ? ST_DRAIN : ST_FETCH;
        default:  state_nxt = ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: begin
          if (IMEM_BUSYWAIT) begin
            if (STALL) ifid_hold  = 1'b1;
            else       ifid_flush = 1'b1;
          end else if (STALL) begin
            ifid_hold     = 1'b1;
            buf_pc_nxt    = pc;
            buf_instr_nxt = IMEM_READDATA;
            pc_nxt        = pc + 32'd4;
            state_nxt     = ST_HOLD;
          end else begin
            ifid_load = 1'b1;
            pc_nxt    = pc + 32'd4;
          end
        end
        ST_HOLD: begin
          if (STALL) begin
            ifid_hold = 1'b1;
          end else begin
            ifid_load      = 1'b1;
            ifid_src_pc    = buf_pc;
            ifid_src_instr = buf_instr;
            state_nxt      = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // The stale word is simply dropped once memory lets go.
          ifid_hold = 1'b1;
          if (!IMEM_BUSYWAIT) state_nxt = ST_FETCH;
        end
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_FETCH;
      pc         <= word_align(RESET_PC);
      drain_addr <= 32'd0;
      buf_pc     <= 32'd0;
      buf_instr  <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
      buf_pc     <= buf_pc_nxt;
      buf_instr  <= buf_instr_nxt;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk        (CLK),
    .rst_n      (RESET),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .hold       (ifid_hold),
    .pc         (ifid_src_pc),
    .instr      (ifid_src_instr),
    .ifid_pc    (IFID_PC),
    .ifid_pc4   (IFID_PC4),
    .ifid_instr (IFID_INSTRUCTION),
    .ifid_valid (IFID_VALID)
  );

  // Gating with reset drops the request the instant reset asserts.
  assign IMEM_READ    = RESET & (state != ST_HOLD);
  assign IMEM_ADDRESS = (state == ST_DRAIN) ? drain_addr : pc;
  assign FETCH_BUSY   = IMEM_READ & IMEM_BUSYWAIT;

  assign OPCODE = {1'b0, IFID_INSTRUCTION[6:0]};
  assign FUNC3  = IFID_INSTRUCTION[14:12];
  assign FUNC7  = IFID_INSTRUCTION[31:25];

endmodule
